msg_stream_arbiter: RTL and testbench

MSG_STREAM_ARBITER -- requirements
Module: msg_stream_arbiter

---
 rtl/msg_stream_arbiter_pkg.sv | 28 ++
 rtl/msg_stream_arbiter_if.sv | 37 +++
 rtl/msg_idle_timer.sv | 34 +++
 rtl/msg_stream_arbiter.sv | 117 +++++++++++
 tb/tb_msg_stream_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_stream_arbiter_pkg.sv
// Shared types and constants for the two-port message stream arbiter.
package msg_stream_arbiter_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned IDLE_CNT_W = 16;

  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_GRANT0 = 3'd1;
  localparam logic [2:0] STATE_GRANT1 = 3'd2;
  localparam logic [2:0] STATE_ABORT  = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = STATE_IDLE,
    ST_GRANT0 = STATE_GRANT0,
    ST_GRANT1 = STATE_GRANT1,
    ST_ABORT  = STATE_ABORT
  } state_t;

  // One beat on the merged output stream.
  typedef struct packed {
    logic              vld;
    logic              sop;
    logic              eop;
    logic              err;
    logic [DATA_W-1:0] data;
  } out_beat_t;

endpackage

// File: rtl/msg_stream_arbiter_if.sv
// Bundle of the two requester streams and the merged output stream.
//   slave  : arbiter side (consumes din*, produces din*_rdy and dout*)
//   master : environment side
interface msg_stream_arbiter_if;
  import msg_stream_arbiter_pkg::*;

  logic [DATA_W-1:0] din0;
  logic              din0_vld;
  logic              din0_sop;
  logic              din0_eop;
  logic              din0_rdy;
  logic [DATA_W-1:0] din1;
  logic              din1_vld;
  logic              din1_sop;
  logic              din1_eop;
  logic              din1_rdy;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_sop;
  logic              dout_eop;
  logic              dout_err;

  modport slave (
    input  din0, din0_vld, din0_sop, din0_eop,
    input  din1, din1_vld, din1_sop, din1_eop,
    output din0_rdy, din1_rdy,
    output dout, dout_vld, dout_sop, dout_eop, dout_err
  );

  modport master (
    output din0, din0_vld, din0_sop, din0_eop,
    output din1, din1_vld, din1_sop, din1_eop,
    input  din0_rdy, din1_rdy,
    input  dout, dout_vld, dout_sop, dout_eop, dout_err
  );

endinterface

// File: rtl/msg_idle_timer.sv
// Idle counter for a granted packet; flags expiry when the count has
// reached TIMEOUT-1 in a cycle that is still idle.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the counter (takes priority over en)
//   en         : count this cycle (granted, no transfer)
//   expire_c   : combinational timeout flag
module msg_idle_timer
  import msg_stream_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [IDLE_CNT_W-1:0] cnt_q;

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + IDLE_CNT_W'(1);
    end
  end

  assign expire_c = en && (cnt_q == IDLE_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/msg_stream_arbiter.sv
// Two-port packet arbiter merging byte streams onto one output with
// round-robin grant on contention and idle-timeout abort.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave modport; din0*/din1* requester streams with
//                combinational rdy, dout* registered merged stream
//   TIMEOUT    : idle cycles tolerated inside a grant before abort
module msg_stream_arbiter
  import msg_stream_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  msg_stream_arbiter_if.slave   bus
);

  state_t            state_q, state_n;
  logic              last_grant_q, last_grant_n;
  logic              seen_q, seen_n;
  out_beat_t         out_q, out_n;

  logic              req0, req1;
  logic              in_grant, gnt_idx, xfer;
  logic [DATA_W-1:0] sel_data;
  logic              sel_eop;
  logic              expire;

  assign req0     = bus.din0_vld && bus.din0_sop;
  assign req1     = bus.din1_vld && bus.din1_sop;
  assign in_grant = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
  assign gnt_idx  = (state_q == ST_GRANT1);
  assign xfer     = ((state_q == ST_GRANT0) && bus.din0_vld) ||
                    ((state_q == ST_GRANT1) && bus.din1_vld);
  assign sel_data = gnt_idx ? bus.din1 : bus.din0;
  assign sel_eop  = gnt_idx ? bus.din1_eop : bus.din0_eop;

  // In IDLE, non-sop bytes are swallowed; sop bytes wait for their grant.
  assign bus.din0_rdy = rst_n && (((state_q == ST_IDLE) && !bus.din0_sop) ||
                                  (state_q == ST_GRANT0));
  assign bus.din1_rdy = rst_n && (((state_q == ST_IDLE) && !bus.din1_sop) ||
                                  (state_q == ST_GRANT1));

  msg_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!in_grant || xfer),
    .en       (in_grant && !xfer),
    .expire_c (expire)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      seen_q       <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_n;
      last_grant_q <= last_grant_n;
      seen_q       <= seen_n;
      out_q        <= out_n;
    end
  end

  // Next state, grant bookkeeping and next output beat
  always_comb begin
    state_n      = state_q;
    last_grant_n = last_grant_q;
    seen_n       = seen_q;
    out_n        = '0;
    case (state_q)
      ST_IDLE: begin
        seen_n = 1'b0;
        if (req0 && req1) begin
          state_n = last_grant_q ? ST_GRANT0 : ST_GRANT1;
        end else if (req0) begin
          state_n = ST_GRANT0;
        end else if (req1) begin
          state_n = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (xfer) begin
          out_n.vld  = 1'b1;
          out_n.sop  = !seen_q;
          out_n.eop  = sel_eop;
          out_n.data = sel_data;
          seen_n     = 1'b1;
          if (sel_eop) begin
            state_n      = ST_IDLE;
            last_grant_n = gnt_idx;
          end
        end else if (expire) begin
          // Abort beat is loaded here so it is on dout during ABORT.
          out_n.vld    = 1'b1;
          out_n.sop    = !seen_q;
          out_n.eop    = 1'b1;
          out_n.err    = 1'b1;
          state_n      = ST_ABORT;
          last_grant_n = gnt_idx;
        end
      end
      ST_ABORT: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign bus.dout     = out_q.data;
  assign bus.dout_vld = out_q.vld;
  assign bus.dout_sop = out_q.sop;
  assign bus.dout_eop = out_q.eop;
  assign bus.dout_err = out_q.err;

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Bench for msg_stream_arbiter: directed scenarios plus random two-port
// packet traffic checked against a per-port packet scoreboard.
module tb_msg_stream_arbiter;
  import msg_stream_arbiter_pkg::*;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  msg_stream_arbiter_if bus();

  msg_stream_arbiter #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    int         gap;
  } tx_t;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
    int         cyc;
  } rx_t;

  tx_t tx0[$];
  tx_t tx1[$];
  rx_t mon_q[$];
  rx_t exp_q[$];
  rx_t ex0[$];
  rx_t ex1[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  always @(negedge clk) begin : monitor
    rx_t r;
    if (bus.dout_vld === 1'b1) begin
      r.d   = bus.dout;
      r.sop = bus.dout_sop;
      r.eop = bus.dout_eop;
      r.err = bus.dout_err;
      r.cyc = cyc;
      mon_q.push_back(r);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int p, logic v, logic s, logic e, logic [7:0] d);
    if (p == 0) begin
      bus.din0_vld = v; bus.din0_sop = s; bus.din0_eop = e; bus.din0 = d;
    end else begin
      bus.din1_vld = v; bus.din1_sop = s; bus.din1_eop = e; bus.din1 = d;
    end
  endtask

  task automatic add_tx(int p, logic [7:0] d, logic s, logic e, int gap);
    tx_t t;
    t.d = d; t.sop = s; t.eop = e; t.gap = gap;
    if (p == 0) tx0.push_back(t);
    else        tx1.push_back(t);
  endtask

  task automatic add_pkt(int p, logic [7:0] base, int len);
    for (int i = 0; i < len; i++)
      add_tx(p, 8'(base + 8'(i)), (i == 0), (i == len - 1), 0);
  endtask

  task automatic push_exp(logic [7:0] d, logic s, logic e, logic er);
    rx_t r;
    r.d = d; r.sop = s; r.eop = e; r.err = er; r.cyc = 0;
    exp_q.push_back(r);
  endtask

  task automatic clear_q();
    mon_q.delete();
    exp_q.delete();
  endtask

  // Drives both port queues concurrently, honouring rdy and per-beat gaps.
  task automatic run_traffic(int budget, int drain);
    int   w0, w1;
    logic f0, f1;
    w0 = (tx0.size() > 0) ? tx0[0].gap : 0;
    w1 = (tx1.size() > 0) ? tx1[0].gap : 0;
    for (int c = 0; c < budget && (tx0.size() + tx1.size() > 0); c++) begin
      if (tx0.size() > 0 && w0 == 0) drive(0, 1'b1, tx0[0].sop, tx0[0].eop, tx0[0].d);
      else                           drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (tx1.size() > 0 && w1 == 0) drive(1, 1'b1, tx1[0].sop, tx1[0].eop, tx1[0].d);
      else                           drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      f0 = bus.din0_vld && bus.din0_rdy;
      f1 = bus.din1_vld && bus.din1_rdy;
      tick();
      if (f0) begin
        tx0.delete(0);
        w0 = (tx0.size() > 0) ? tx0[0].gap : 0;
      end else if (w0 > 0) w0--;
      if (f1) begin
        tx1.delete(0);
        w1 = (tx1.size() > 0) ? tx1[0].gap : 0;
      end else if (w1 > 0) w1--;
    end
    chk("traffic_drained", 32'(tx0.size() + tx1.size()), 32'(0));
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (drain) tick();
  endtask

  task automatic check_mon(string tag);
    chk($sformatf("%s_count", tag), 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i),
          32'({mon_q[i].d, mon_q[i].sop, mon_q[i].eop, mon_q[i].err}),
          32'({exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].err}));
  endtask

  // Only IDLE accepts non-sop bytes on both ports at once.
  task automatic check_idle(string tag);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h5A);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h3C);
    @(negedge clk);
    chk(tag, 32'({bus.din0_rdy, bus.din1_rdy}), 32'(2'b11));
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) tick();
  endtask

  task automatic gen_random();
    int   len;
    rx_t  r;
    logic [7:0] d;
    for (int k = 0; k < 15; k++) begin
      for (int p = 0; p < 2; p++) begin
        len = int'($urandom_range(1, 6));
        for (int i = 0; i < len; i++) begin
          d = {(p == 1), 7'($urandom)};
          add_tx(p, d, (i == 0), (i == len - 1),
                 (i == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3)));
          r.d = d; r.sop = (i == 0); r.eop = (i == len - 1); r.err = 1'b0; r.cyc = 0;
          if (p == 0) ex0.push_back(r);
          else        ex1.push_back(r);
        end
      end
    end
  endtask

  // Every output packet must be the next packet of exactly one port.
  task automatic score_random();
    int  cur;
    int  last_eop;
    int  qsz;
    rx_t r;
    rx_t e;
    cur      = -1;
    last_eop = -100;
    foreach (mon_q[i]) begin
      r = mon_q[i];
      if (r.sop) begin
        cur = r.d[7] ? 1 : 0;
        chk("rand_gap", 32'(r.cyc - last_eop >= 2), 32'(1));
      end
      if (cur < 0) begin
        chk("rand_orphan_beat_sop", 32'(r.sop), 32'(1));
      end else begin
        qsz = (cur == 0) ? ex0.size() : ex1.size();
        chk("rand_beat_expected", 32'(qsz != 0), 32'(1));
        if (qsz != 0) begin
          if (cur == 0) e = ex0.pop_front();
          else          e = ex1.pop_front();
          chk($sformatf("rand_beat%0d", i),
              32'({r.d, r.sop, r.eop, r.err}), 32'({e.d, e.sop, e.eop, e.err}));
        end
      end
      if (r.eop) begin
        last_eop = r.cyc;
        cur      = -1;
      end
    end
    chk("rand_port0_left", 32'(ex0.size()), 32'(0));
    chk("rand_port1_left", 32'(ex1.size()), 32'(0));
  endtask

  initial begin : stim
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h99);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({bus.dout_vld, bus.dout_sop, bus.dout_eop,
                              bus.dout_err, bus.dout}), 32'(0));
    chk("reset_rdy", 32'({bus.din0_rdy, bus.din1_rdy}), 32'(0));
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b1;
    tick();
    check_idle("first_cycle_idle");
    clear_q();

    // Contention straight after reset: port0, port1, port0
    add_pkt(0, 8'h01, 3);
    add_pkt(1, 8'h81, 2);
    add_pkt(0, 8'h04, 2);
    run_traffic(200, 4);
    push_exp(8'h01, 1'b1, 1'b0, 1'b0);
    push_exp(8'h02, 1'b0, 1'b0, 1'b0);
    push_exp(8'h03, 1'b0, 1'b1, 1'b0);
    push_exp(8'h81, 1'b1, 1'b0, 1'b0);
    push_exp(8'h82, 1'b0, 1'b1, 1'b0);
    push_exp(8'h04, 1'b1, 1'b0, 1'b0);
    push_exp(8'h05, 1'b0, 1'b1, 1'b0);
    check_mon("contest");
    if (mon_q.size() == 7) begin
      chk("contest_gap_a_b", 32'(mon_q[3].cyc - mon_q[2].cyc), 32'(2));
      chk("contest_gap_b_c", 32'(mon_q[5].cyc - mon_q[4].cyc), 32'(2));
    end
    clear_q();

    // Three-byte packet on port0
    add_tx(0, 8'h11, 1'b1, 1'b0, 0);
    add_tx(0, 8'h22, 1'b0, 1'b0, 0);
    add_tx(0, 8'h33, 1'b0, 1'b1, 0);
    run_traffic(100, 4);
    push_exp(8'h11, 1'b1, 1'b0, 1'b0);
    push_exp(8'h22, 1'b0, 1'b0, 1'b0);
    push_exp(8'h33, 1'b0, 1'b1, 1'b0);
    check_mon("three_byte");
    if (mon_q.size() == 3)
      chk("three_byte_back_to_back", 32'(mon_q[2].cyc - mon_q[0].cyc), 32'(2));
    clear_q();

    // Single-byte packet
    add_tx(0, 8'h7E, 1'b1, 1'b1, 0);
    run_traffic(100, 3);
    push_exp(8'h7E, 1'b1, 1'b1, 1'b0);
    check_mon("single");
    check_idle("single_back_to_idle");
    clear_q();

    // Stray byte in IDLE is accepted and dropped
    drive(1, 1'b1, 1'b0, 1'b0, 8'h99);
    @(negedge clk);
    chk("stray_rdy1", 32'(bus.din1_rdy), 32'(1));
    repeat (3) tick();
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    check_mon("stray");
    clear_q();

    // Timeout after one byte on port1
    add_tx(1, 8'hA5, 1'b1, 1'b0, 0);
    run_traffic(50, 12);
    push_exp(8'hA5, 1'b1, 1'b0, 1'b0);
    push_exp(8'h00, 1'b0, 1'b1, 1'b1);
    check_mon("timeout");
    if (mon_q.size() == 2)
      chk("timeout_spacing", 32'(mon_q[1].cyc - mon_q[0].cyc), 32'(TMO));
    check_idle("timeout_back_to_idle");
    clear_q();
    add_pkt(0, 8'h21, 2);
    add_pkt(1, 8'hC1, 2);
    run_traffic(100, 4);
    push_exp(8'h21, 1'b1, 1'b0, 1'b0);
    push_exp(8'h22, 1'b0, 1'b1, 1'b0);
    push_exp(8'hC1, 1'b1, 1'b0, 1'b0);
    push_exp(8'hC2, 1'b0, 1'b1, 1'b0);
    check_mon("post_abort_contest");
    clear_q();

    // Timeout before any byte moves: abort beat carries sop
    drive(0, 1'b1, 1'b1, 1'b0, 8'h66);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h77);
    @(negedge clk);
    chk("grant0_rdy", 32'({bus.din0_rdy, bus.din1_rdy}), 32'(2'b10));
    tick();
    repeat (7) tick();
    @(negedge clk);
    chk("abort_rdy", 32'({bus.din0_rdy, bus.din1_rdy}), 32'(0));
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    push_exp(8'h00, 1'b1, 1'b1, 1'b1);
    check_mon("empty_abort");
    clear_q();

    // Reset in the middle of a port0 packet
    drive(0, 1'b1, 1'b1, 1'b0, 8'h41);
    tick();
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 8'h42);
    chk("pre_reset_vld", 32'(bus.dout_vld), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({bus.dout_vld, bus.dout_sop, bus.dout_eop,
                                  bus.dout_err, bus.dout}), 32'(0));
    chk("mid_reset_rdy0", 32'(bus.din0_rdy), 32'(0));
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    clear_q();
    add_pkt(1, 8'hD1, 3);
    run_traffic(100, 4);
    push_exp(8'hD1, 1'b1, 1'b0, 1'b0);
    push_exp(8'hD2, 1'b0, 1'b0, 1'b0);
    push_exp(8'hD3, 1'b0, 1'b1, 1'b0);
    check_mon("after_reset");
    clear_q();

    // Random two-port traffic
    gen_random();
    run_traffic(4000, 4);
    score_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
